// File: rtl/xlate_pkg.sv
// Shared types and constants for the address translation unit:
// FSM state encoding, exception codes, CSR field positions and PLV encodings.
package xlate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TLB_REQ  = 3'd1,
    ST_TLB_WAIT = 3'd2,
    ST_RESP     = 3'd3,
    ST_DRAIN    = 3'd4
  } state_t;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADE  = 3'd1;
  localparam logic [2:0] EXC_TLBR = 3'd2;
  localparam logic [2:0] EXC_PIX  = 3'd3;
  localparam logic [2:0] EXC_PPI  = 3'd4;

  // CRMD fields
  localparam int CRMD_PLV_LSB = 0;
  localparam int CRMD_DA      = 3;
  localparam int CRMD_PG      = 4;

  // DMW fields
  localparam int DMW_PLV0     = 0;
  localparam int DMW_PLV3     = 3;
  localparam int DMW_PSEG_MSB = 27;
  localparam int DMW_VSEG_MSB = 31;

  localparam logic [1:0] PLV_KERNEL = 2'd0;
  localparam logic [1:0] PLV_USER   = 2'd3;

  // A page is privilege-protected when the current level is less privileged
  // (numerically larger) than the level recorded in the TLB entry.
  function automatic logic plv_violation(input logic [1:0] cur_plv,
                                         input logic [1:0] entry_plv);
    return cur_plv > entry_plv;
  endfunction

endpackage

// File: rtl/addr_xlate_unit_if.sv
// Bundles the request, response and TLB lookup handshakes of the translation
// unit. "slave" is the unit's view; "master" is the requester/TLB side.
interface addr_xlate_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_vaddr;

  logic              tlb_req_valid;
  logic              tlb_req_ready;
  logic [ADDR_W-1:0] tlb_req_vaddr;

  logic              tlb_resp_valid;
  logic              tlb_resp_found;
  logic              tlb_resp_v;
  logic [1:0]        tlb_resp_plv;
  logic [ADDR_W-1:0] tlb_resp_paddr;

  logic              resp_valid;
  logic              resp_ready;
  logic [ADDR_W-1:0] resp_paddr;
  logic [2:0]        resp_exc;
  logic              resp_mapped;

  modport slave (
    input  req_valid, req_vaddr, tlb_req_ready,
           tlb_resp_valid, tlb_resp_found, tlb_resp_v, tlb_resp_plv, tlb_resp_paddr,
           resp_ready,
    output req_ready, tlb_req_valid, tlb_req_vaddr,
           resp_valid, resp_paddr, resp_exc, resp_mapped
  );

  modport master (
    output req_valid, req_vaddr, tlb_req_ready,
           tlb_resp_valid, tlb_resp_found, tlb_resp_v, tlb_resp_plv, tlb_resp_paddr,
           resp_ready,
    input  req_ready, tlb_req_valid, tlb_req_vaddr,
           resp_valid, resp_paddr, resp_exc, resp_mapped
  );
endinterface

// File: rtl/dmw_match.sv
// Combinational match of one direct-map window against a virtual address.
// A hit needs the current PLV enabled in the window (only PLV0/PLV3 can be)
// and the top segment bits equal to VSEG; the segment is then replaced by PSEG.
module dmw_match
  import xlate_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int VSEG_W = 3
) (
  input  logic [ADDR_W-1:0] vaddr,
  input  logic [1:0]        plv,
  input  logic [31:0]       dmw,
  output logic              hit,
  output logic [ADDR_W-1:0] paddr
);

  logic plv_ok;

  // MAT and reserved bits carry no meaning for translation.
  wire unused_dmw = ^dmw;

  assign plv_ok = ((plv == PLV_KERNEL) && dmw[DMW_PLV0]) ||
                  ((plv == PLV_USER)   && dmw[DMW_PLV3]);
  assign hit    = plv_ok && (vaddr[ADDR_W-1 -: VSEG_W] == dmw[DMW_VSEG_MSB -: VSEG_W]);
  assign paddr  = {dmw[DMW_PSEG_MSB -: VSEG_W], vaddr[ADDR_W-VSEG_W-1:0]};

endmodule

// File: rtl/addr_xlate_unit.sv
// Virtual->physical translation unit. Direct mode, DMW hits and the
// user-mode high-half address error resolve in one cycle; all other mapped
// addresses go to the shared TLB over a valid/ready handshake. One
// translation in flight; flush aborts, draining an outstanding TLB lookup.
module addr_xlate_unit
  import xlate_pkg::*;
#(
  parameter int NUM_DMW = 2,
  parameter int ADDR_W  = 32,
  parameter int VSEG_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [31:0]          csr_crmd,
  input  logic [32*NUM_DMW-1:0] csr_dmw,
  addr_xlate_unit_if.slave     bus
);

  state_t            state;
  logic              req_ready_reg;
  logic              tlb_req_valid_reg;
  logic              resp_valid_reg;
  logic [ADDR_W-1:0] resp_paddr_reg;
  logic [2:0]        resp_exc_reg;
  logic              resp_mapped_reg;
  logic [ADDR_W-1:0] vaddr_reg;
  logic [1:0]        plv_reg;

  logic [1:0]        crmd_plv;
  logic              direct_mode;
  logic [NUM_DMW-1:0] dmw_hit;
  logic [ADDR_W-1:0] dmw_paddr [NUM_DMW];
  logic              any_hit;
  logic [ADDR_W-1:0] hit_paddr;
  logic              ade;

  // Only DA, PG and PLV of CRMD matter here.
  wire unused_crmd = ^csr_crmd;

  assign crmd_plv    = csr_crmd[CRMD_PLV_LSB +: 2];
  // DA wins over PG; DA=PG=0 is also treated as direct.
  assign direct_mode = csr_crmd[CRMD_DA] || !csr_crmd[CRMD_PG];

  for (genvar gi = 0; gi < NUM_DMW; gi++) begin : g_dmw
    dmw_match #(
      .ADDR_W (ADDR_W),
      .VSEG_W (VSEG_W)
    ) u_dmw_match (
      .vaddr (bus.req_vaddr),
      .plv   (crmd_plv),
      .dmw   (csr_dmw[32*gi +: 32]),
      .hit   (dmw_hit[gi]),
      .paddr (dmw_paddr[gi])
    );
  end

  // Priority encode DMW hits: scanning downward lets window 0 win last.
  always_comb begin
    any_hit   = 1'b0;
    hit_paddr = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if (dmw_hit[i]) begin
        any_hit   = 1'b1;
        hit_paddr = dmw_paddr[i];
      end
    end
  end

  // User code touching the upper half without a DMW is rejected before the TLB.
  assign ade = !any_hit && bus.req_vaddr[ADDR_W-1] && (crmd_plv == PLV_USER);

  // Translation FSM with all handshake/result outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      req_ready_reg     <= 1'b1;
      tlb_req_valid_reg <= 1'b0;
      resp_valid_reg    <= 1'b0;
      resp_paddr_reg    <= '0;
      resp_exc_reg      <= EXC_NONE;
      resp_mapped_reg   <= 1'b0;
      vaddr_reg         <= '0;
      plv_reg           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!flush && bus.req_valid) begin
            vaddr_reg     <= bus.req_vaddr;
            plv_reg       <= crmd_plv;
            req_ready_reg <= 1'b0;
            if (direct_mode || any_hit || ade) begin
              state           <= ST_RESP;
              resp_valid_reg  <= 1'b1;
              resp_mapped_reg <= 1'b0;
              if (direct_mode) begin
                resp_paddr_reg <= bus.req_vaddr;
                resp_exc_reg   <= EXC_NONE;
              end else if (any_hit) begin
                resp_paddr_reg <= hit_paddr;
                resp_exc_reg   <= EXC_NONE;
              end else begin
                resp_paddr_reg <= '0;
                resp_exc_reg   <= EXC_ADE;
              end
            end else begin
              state             <= ST_TLB_REQ;
              tlb_req_valid_reg <= 1'b1;
            end
          end
        end

        ST_TLB_REQ: begin
          if (flush) begin
            tlb_req_valid_reg <= 1'b0;
            if (bus.tlb_req_ready) begin
              state <= ST_DRAIN;
            end else begin
              state         <= ST_IDLE;
              req_ready_reg <= 1'b1;
            end
          end else if (bus.tlb_req_ready) begin
            state             <= ST_TLB_WAIT;
            tlb_req_valid_reg <= 1'b0;
          end
        end

        ST_TLB_WAIT: begin
          if (flush) begin
            if (bus.tlb_resp_valid) begin
              state         <= ST_IDLE;
              req_ready_reg <= 1'b1;
            end else begin
              state <= ST_DRAIN;
            end
          end else if (bus.tlb_resp_valid) begin
            state           <= ST_RESP;
            resp_valid_reg  <= 1'b1;
            resp_mapped_reg <= 1'b1;
            if (!bus.tlb_resp_found) begin
              resp_paddr_reg <= '0;
              resp_exc_reg   <= EXC_TLBR;
            end else if (!bus.tlb_resp_v) begin
              resp_paddr_reg <= '0;
              resp_exc_reg   <= EXC_PIX;
            end else if (plv_violation(plv_reg, bus.tlb_resp_plv)) begin
              resp_paddr_reg <= '0;
              resp_exc_reg   <= EXC_PPI;
            end else begin
              resp_paddr_reg <= bus.tlb_resp_paddr;
              resp_exc_reg   <= EXC_NONE;
            end
          end
        end

        ST_RESP: begin
          if (flush || bus.resp_ready) begin
            state          <= ST_IDLE;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (bus.tlb_resp_valid) begin
            state         <= ST_IDLE;
            req_ready_reg <= 1'b1;
          end
        end

        default: begin
          state             <= ST_IDLE;
          req_ready_reg     <= 1'b1;
          tlb_req_valid_reg <= 1'b0;
          resp_valid_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_reg;
  assign bus.tlb_req_valid = tlb_req_valid_reg;
  assign bus.tlb_req_vaddr = vaddr_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_paddr    = resp_paddr_reg;
  assign bus.resp_exc      = resp_exc_reg;
  assign bus.resp_mapped   = resp_mapped_reg;

endmodule

// File: tb/tb_addr_xlate_unit.sv
// Directed bench for addr_xlate_unit: direct mode, DMW hits/priority,
// address error, TLB outcomes, response backpressure and flush cases.
module tb_addr_xlate_unit;

  localparam int ADDR_W = 32;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] csr_crmd;
  logic [63:0] csr_dmw;

  int total;
  int bad;
  int tlb_cycles;
  int snap;

  addr_xlate_unit_if #(.ADDR_W(ADDR_W)) bus ();

  addr_xlate_unit #(
    .NUM_DMW (2),
    .ADDR_W  (ADDR_W),
    .VSEG_W  (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .csr_crmd (csr_crmd),
    .csr_dmw  (csr_dmw),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every cycle in which a TLB lookup is being requested.
  always @(posedge clk) begin
    if (bus.tlb_req_valid === 1'b1) tlb_cycles <= tlb_cycles + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle.
  task automatic issue(input logic [31:0] vaddr);
    bus.req_valid = 1'b1;
    bus.req_vaddr = vaddr;
    tick();
    bus.req_valid = 1'b0;
  endtask

  // Accept the response and confirm the unit returns to idle.
  task automatic consume(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check_val({tag, "_rv_clr"}, {31'd0, bus.resp_valid}, 32'd0);
    check_val({tag, "_rdy"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  // Serve the TLB lookup: hold ready low for 'delay' cycles, then handshake,
  // then return the given entry in the next cycle.
  task automatic tlb_serve(input string tag, input int delay, input logic found,
                           input logic v, input logic [1:0] eplv, input logic [31:0] epaddr);
    for (int i = 0; i < delay; i++) begin
      check_val({tag, "_tlbv_hold"}, {31'd0, bus.tlb_req_valid}, 32'd1);
      tick();
    end
    check_val({tag, "_tlb_vaddr"}, bus.tlb_req_vaddr, 32'h0040_0000);
    bus.tlb_req_ready = 1'b1;
    tick();
    bus.tlb_req_ready  = 1'b0;
    check_val({tag, "_tlbv_drop"}, {31'd0, bus.tlb_req_valid}, 32'd0);
    bus.tlb_resp_valid = 1'b1;
    bus.tlb_resp_found = found;
    bus.tlb_resp_v     = v;
    bus.tlb_resp_plv   = eplv;
    bus.tlb_resp_paddr = epaddr;
    tick();
    bus.tlb_resp_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    tlb_cycles = 0;
    reset = 1'b1;
    flush = 1'b0;
    csr_crmd = 32'h0;
    csr_dmw  = 64'h0;
    bus.req_valid      = 1'b0;
    bus.req_vaddr      = 32'h0;
    bus.tlb_req_ready  = 1'b0;
    bus.tlb_resp_valid = 1'b0;
    bus.tlb_resp_found = 1'b0;
    bus.tlb_resp_v     = 1'b0;
    bus.tlb_resp_plv   = 2'd0;
    bus.tlb_resp_paddr = 32'h0;
    bus.resp_ready     = 1'b0;
    tick();
    tick();

    // Reset state
    check_val("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check_val("rst_tlb_valid", {31'd0, bus.tlb_req_valid}, 32'd0);
    check_val("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check_val("rst_paddr", bus.resp_paddr, 32'd0);
    check_val("rst_exc", {29'd0, bus.resp_exc}, 32'd0);
    check_val("rst_mapped", {31'd0, bus.resp_mapped}, 32'd0);
    reset = 1'b0;
    tick();

    // Direct mode (DA=1): identity, one cycle
    csr_crmd = 32'h0000_0008;
    snap = tlb_cycles;
    issue(32'h1234_5678);
    check_val("da_valid", {31'd0, bus.resp_valid}, 32'd1);
    check_val("da_paddr", bus.resp_paddr, 32'h1234_5678);
    check_val("da_exc", {29'd0, bus.resp_exc}, 32'd0);
    check_val("da_mapped", {31'd0, bus.resp_mapped}, 32'd0);
    check_val("da_rdy_low", {31'd0, bus.req_ready}, 32'd0);
    consume("da");
    check_val("da_no_tlb", tlb_cycles - snap, 32'd0);

    // DMW0 hit at PLV0: VSEG=100, PSEG=000; 0x9000_1000 keeps its low 29 bits
    csr_crmd = 32'h0000_0010;
    csr_dmw  = {32'h0, 32'h9000_0001};
    issue(32'h9000_1000);
    check_val("dmw0_valid", {31'd0, bus.resp_valid}, 32'd1);
    check_val("dmw0_paddr", bus.resp_paddr, 32'h1000_1000);
    check_val("dmw0_exc", {29'd0, bus.resp_exc}, 32'd0);
    consume("dmw0");
    issue(32'h8000_1000);
    check_val("dmw0b_paddr", bus.resp_paddr, 32'h0000_1000);
    consume("dmw0b");

    // Both windows match: window 0 (PSEG 000) beats window 1 (PSEG 111)
    csr_dmw = {32'h9E00_0001, 32'h9000_0001};
    issue(32'h9000_1000);
    check_val("dmw_prio_paddr", bus.resp_paddr, 32'h1000_1000);
    consume("dmw_prio");
    // Window 1 alone
    csr_dmw = {32'h9E00_0001, 32'h0};
    issue(32'h9000_1000);
    check_val("dmw1_paddr", bus.resp_paddr, 32'hF000_1000);
    consume("dmw1");

    // PLV3, no DMW, upper-half address -> ADE without any TLB access
    csr_crmd = 32'h0000_0013;
    csr_dmw  = 64'h0;
    snap = tlb_cycles;
    issue(32'h8000_0000);
    check_val("ade_valid", {31'd0, bus.resp_valid}, 32'd1);
    check_val("ade_exc", {29'd0, bus.resp_exc}, 32'd1);
    check_val("ade_paddr", bus.resp_paddr, 32'd0);
    consume("ade");
    check_val("ade_no_tlb", tlb_cycles - snap, 32'd0);

    // TLB hit with ready delayed 2 cycles, then hold response for 5 cycles
    issue(32'h0040_0000);
    check_val("tlb_ok_resp_wait", {31'd0, bus.resp_valid}, 32'd0);
    tlb_serve("tlb_ok", 2, 1'b1, 1'b1, 2'd3, 32'h0123_4000);
    for (int i = 0; i < 5; i++) begin
      check_val("stall_valid", {31'd0, bus.resp_valid}, 32'd1);
      check_val("stall_paddr", bus.resp_paddr, 32'h0123_4000);
      check_val("stall_exc", {29'd0, bus.resp_exc}, 32'd0);
      check_val("stall_mapped", {31'd0, bus.resp_mapped}, 32'd1);
      check_val("stall_rdy_low", {31'd0, bus.req_ready}, 32'd0);
      tick();
    end
    consume("tlb_ok");

    // TLB miss -> TLBR
    issue(32'h0040_0000);
    tlb_serve("tlbr", 0, 1'b0, 1'b1, 2'd3, 32'h0123_4000);
    check_val("tlbr_exc", {29'd0, bus.resp_exc}, 32'd2);
    check_val("tlbr_paddr", bus.resp_paddr, 32'd0);
    consume("tlbr");

    // Invalid entry -> PIX
    issue(32'h0040_0000);
    tlb_serve("pix", 1, 1'b1, 1'b0, 2'd3, 32'h0123_4000);
    check_val("pix_exc", {29'd0, bus.resp_exc}, 32'd3);
    consume("pix");

    // Kernel-only entry accessed at PLV3 -> PPI
    issue(32'h0040_0000);
    tlb_serve("ppi", 0, 1'b1, 1'b1, 2'd0, 32'h0123_4000);
    check_val("ppi_exc", {29'd0, bus.resp_exc}, 32'd4);
    consume("ppi");

    // Flush in TLB_WAIT: drain until the late TLB response, no result emitted
    issue(32'h0040_0000);
    bus.tlb_req_ready = 1'b1;
    tick();
    bus.tlb_req_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("drain_rdy_low", {31'd0, bus.req_ready}, 32'd0);
      check_val("drain_no_resp", {31'd0, bus.resp_valid}, 32'd0);
      tick();
    end
    bus.tlb_resp_valid = 1'b1;
    bus.tlb_resp_found = 1'b1;
    bus.tlb_resp_v     = 1'b1;
    tick();
    bus.tlb_resp_valid = 1'b0;
    check_val("drain_done_rdy", {31'd0, bus.req_ready}, 32'd1);
    check_val("drain_done_resp", {31'd0, bus.resp_valid}, 32'd0);

    // Flush in RESP: result withdrawn next cycle
    csr_crmd = 32'h0000_0008;
    issue(32'h0000_00A0);
    check_val("fl_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("fl_resp_clr", {31'd0, bus.resp_valid}, 32'd0);
    check_val("fl_resp_rdy", {31'd0, bus.req_ready}, 32'd1);

    // Flush with request in IDLE: not accepted
    bus.req_valid = 1'b1;
    bus.req_vaddr = 32'h0000_00B0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.req_valid = 1'b0;
    check_val("fl_idle_rdy", {31'd0, bus.req_ready}, 32'd1);
    check_val("fl_idle_noresp", {31'd0, bus.resp_valid}, 32'd0);

    // Reset mid-operation while a TLB lookup is pending
    csr_crmd = 32'h0000_0013;
    issue(32'h0040_0000);
    check_val("mid_tlbv", {31'd0, bus.tlb_req_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_tlbv", {31'd0, bus.tlb_req_valid}, 32'd0);
    check_val("mid_rst_rdy", {31'd0, bus.req_ready}, 32'd1);
    check_val("mid_rst_vaddr", bus.tlb_req_vaddr, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
